lcd_frame_scheduler: RTL and testbench

// - Sits between game logic and the LCD page driver. Owns a double-buffered 2x1024x8 frame store
//   and paces refreshes by pulsing the driver's start strobe once per frame period.
// - Game logic writes the back bank and commits it. The driver reads the front bank.
// - Banks swap only between refreshes, so the driver never scans a half-written frame.

---
 rtl/lcd_frame_scheduler_pkg.sv | 16 +
 rtl/lcd_frame_scheduler_if.sv | 34 +++
 rtl/lcd_frame_scheduler_dpram.sv | 36 +++
 rtl/lcd_frame_scheduler.sv | 154 +++++++++++++++
 tb/tb_lcd_frame_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_frame_scheduler_pkg.sv
// Shared widths and FSM encoding for the LCD frame scheduler.
// Imported by the interface, the frame-store RAM and the top.
package lcd_pkg;

    localparam int LCD_ADDR_W = 10;
    localparam int LCD_DATA_W = 8;

    localparam logic [LCD_ADDR_W-1:0] LCD_LAST_ADDR = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } lcd_state_e;

endpackage

// File: rtl/lcd_frame_scheduler_if.sv
// Game-side and driver-side signals of the frame scheduler.
// slave: scheduler view; master: game logic + driver view.
interface lcd_frame_scheduler_if;
    import lcd_pkg::*;

    logic                  enable_i;
    logic                  wr_en_i;
    logic [LCD_ADDR_W-1:0] wr_addr_i;
    logic [LCD_DATA_W-1:0] wr_data_i;
    logic                  wr_ready_o;
    logic                  commit_i;
    logic                  commit_ack_o;
    logic                  drv_start_o;
    logic [LCD_ADDR_W-1:0] drv_addr_i;
    logic [LCD_DATA_W-1:0] drv_data_o;
    logic                  busy_o;
    logic                  err_o;
    logic [15:0]           frame_cnt_o;

    modport slave (
        input  enable_i, wr_en_i, wr_addr_i, wr_data_i,
        input  commit_i, drv_addr_i,
        output wr_ready_o, commit_ack_o, drv_start_o,
        output drv_data_o, busy_o, err_o, frame_cnt_o
    );

    modport master (
        output enable_i, wr_en_i, wr_addr_i, wr_data_i,
        output commit_i, drv_addr_i,
        input  wr_ready_o, commit_ack_o, drv_start_o,
        input  drv_data_o, busy_o, err_o, frame_cnt_o
    );

endinterface

// File: rtl/lcd_frame_scheduler_dpram.sv
// 2048x8 simple dual-port frame store (two 1024-byte banks).
// Ports: clk, rstn, we_i/waddr_i/wdata_i write, raddr_i/rdata_o registered read.
module lcd_fb_dpram
    import lcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we_i,
    input  logic [LCD_ADDR_W:0]   waddr_i,
    input  logic [LCD_DATA_W-1:0] wdata_i,
    input  logic [LCD_ADDR_W:0]   raddr_i,
    output logic [LCD_DATA_W-1:0] rdata_o
);

    logic [LCD_DATA_W-1:0] mem_q [0:(1<<(LCD_ADDR_W+1))-1];
    logic [LCD_DATA_W-1:0] rdata_q;

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register resets, so drv_data_o reads 0 out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Double-buffered frame store plus refresh pacer for the LCD page driver.
// Ports: clk, rstn, bus (slave): game writes/commit, driver start/addr/data, status.
module lcd_frame_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned PERIOD_CYC  = 500000,
    parameter int unsigned START_HOLD  = 4,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rstn,
    lcd_frame_scheduler_if.slave bus
);

    localparam int PCW = $clog2(PERIOD_CYC);
    localparam int HW  = $clog2(START_HOLD);
    localparam int WDW = $clog2(TIMEOUT_CYC);

    localparam logic [PCW-1:0] PER_LAST  = PCW'(PERIOD_CYC - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(START_HOLD - 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYC - 1);

    lcd_state_e state_q, state_d;

    logic [PCW-1:0]        per_q, per_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [WDW-1:0]        wd_q, wd_d;
    logic [LCD_ADDR_W-1:0] prev_addr_q;
    logic [15:0]           frame_q, frame_d;
    logic                  front_q, front_d;
    logic                  pend_q, pend_d;
    logic                  swap_q;
    logic                  ack_q;
    logic                  err_q, err_d;

    logic tick;
    logic done;
    logic timeout;
    logic swap;
    logic wr_acc;
    logic start_o;
    logic busy_o;

    // Period counter: held at 0 while disabled, tick on wrap.
    always_comb begin
        per_d = '0;
        if (bus.enable_i) begin
            per_d = (per_q == PER_LAST) ? '0 : per_q + 1'b1;
        end
    end

    assign tick = bus.enable_i && (per_q == PER_LAST);

    // Refresh is complete when the driver wraps its scan address.
    assign done = (state_q == RUN)
               && (prev_addr_q == LCD_LAST_ADDR)
               && (bus.drv_addr_i == '0);

    assign timeout = (state_q == RUN) && !done && (wd_q == WD_LAST);

    // Swap only between refreshes: in IDLE, or on the done edge where a
    // same-cycle commit counts as pending.
    assign swap = ((state_q == IDLE) && pend_q)
               || (done && (pend_q || bus.commit_i));

    assign wr_acc = bus.wr_en_i && !pend_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tick) state_d = START;
            START:   if (hold_q == HOLD_LAST) state_d = RUN;
            RUN:     if (done || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_o = 1'b0;
        busy_o  = 1'b0;
        unique case (state_q)
            IDLE:    begin end
            START:   begin start_o = 1'b1; busy_o = 1'b1; end
            RUN:     busy_o = 1'b1;
            default: begin end
        endcase
    end

    always_comb begin
        hold_d  = (state_q == START) ? hold_q + 1'b1 : '0;
        wd_d    = (state_q == RUN) ? wd_q + 1'b1 : '0;
        frame_d = done ? frame_q + 16'd1 : frame_q;
        err_d   = err_q || timeout;
        front_d = swap ? ~front_q : front_q;
        pend_d  = pend_q;
        if (swap) begin
            pend_d = 1'b0;
        end else if (bus.commit_i) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            per_q       <= '0;
            hold_q      <= '0;
            wd_q        <= '0;
            prev_addr_q <= '0;
            frame_q     <= '0;
            front_q     <= 1'b0;
            pend_q      <= 1'b0;
            swap_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            per_q       <= per_d;
            hold_q      <= hold_d;
            wd_q        <= wd_d;
            prev_addr_q <= bus.drv_addr_i;
            frame_q     <= frame_d;
            front_q     <= front_d;
            pend_q      <= pend_d;
            swap_q      <= swap;
            ack_q       <= swap_q;
            err_q       <= err_d;
        end
    end

    lcd_fb_dpram u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (wr_acc),
        .waddr_i ({~front_q, bus.wr_addr_i}),
        .wdata_i (bus.wr_data_i),
        .raddr_i ({front_q, bus.drv_addr_i}),
        .rdata_o (bus.drv_data_o)
    );

    assign bus.wr_ready_o   = ~pend_q;
    assign bus.commit_ack_o = ack_q;
    assign bus.drv_start_o  = start_o;
    assign bus.busy_o       = busy_o;
    assign bus.err_o        = err_q;
    assign bus.frame_cnt_o  = frame_q;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench for lcd_frame_scheduler with a behavioural page driver.
// Pixel expectations go through a scoreboard queue checked after each refresh.
module tb_lcd_frame_scheduler;

    logic clk;
    logic rstn;

    lcd_frame_scheduler_if bus ();

    lcd_frame_scheduler #(
        .PERIOD_CYC  (5000),
        .START_HOLD  (4),
        .TIMEOUT_CYC (4096)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt = 0;
    int start_cnt = 0;
    bit stall = 0;
    bit drv_abort = 0;

    logic [7:0] rdata [0:1023];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rise();
        int n;
        n = 0;
        while (!bus.busy_o && n < 6000) begin
            step(1);
            n++;
        end
        chk("busy_rise", bus.busy_o, 1);
    endtask

    task automatic wait_fall(output int len);
        int n;
        n = 0;
        while (bus.busy_o && n < 6000) begin
            step(1);
            n++;
        end
        len = n;
        chk("busy_fall", bus.busy_o, 0);
    endtask

    task automatic sb_check();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("pix_%03h", e.addr), rdata[e.addr], e.data);
        end
    endtask

    task automatic write(input logic [9:0] a, input logic [7:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = a;
        bus.wr_data_i = d;
        step(1);
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic commit();
        bus.commit_i = 1'b1;
        step(1);
        bus.commit_i = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        static bit ps = 1'b0;
        if (bus.commit_ack_o) ack_cnt++;
        if (bus.drv_start_o && !ps) start_cnt++;
        ps = bus.drv_start_o;
    end

    // Page driver: samples start every 2nd clock, scans on its fall,
    // holds each address 2 clocks and wraps to 0 when finished.
    initial begin : drv_model
        bit ph;
        bit ps;
        ph = 1'b0;
        ps = 1'b0;
        bus.drv_addr_i = '0;
        forever begin
            @(negedge clk);
            bus.drv_addr_i = stall ? 10'h123 : 10'h000;
            ph = ~ph;
            if (ph) begin
                if (ps && !bus.drv_start_o && !stall && !drv_abort) begin
                    @(posedge clk);
                    #1;
                    for (int a = 0; a < 1024; a++) begin
                        if (drv_abort) break;
                        bus.drv_addr_i = 10'(a);
                        @(posedge clk);
                        @(negedge clk);
                        rdata[a] = bus.drv_data_o;
                        @(posedge clk);
                        #1;
                    end
                    bus.drv_addr_i = '0;
                end
                ps = bus.drv_start_o;
            end
        end
    end

    initial begin : stim
        int n;
        int len;
        int ack0;
        int st0;

        rstn          = 1'b0;
        bus.enable_i  = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.commit_i  = 1'b0;

        #23;
        chk("rst_ready", bus.wr_ready_o, 1);
        chk("rst_ack", bus.commit_ack_o, 0);
        chk("rst_start", bus.drv_start_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_frame", bus.frame_cnt_o, 0);
        chk("rst_data", bus.drv_data_o, 0);

        step(2);
        rstn = 1'b1;
        step(2);

        // First refresh: start rises after the 5000th enabled edge.
        bus.enable_i = 1'b1;
        n = 0;
        while (!bus.drv_start_o && n < 6000) begin
            step(1);
            n++;
        end
        chk("start_at", n, 5000);
        chk("busy_start", bus.busy_o, 1);
        n = 0;
        while (bus.drv_start_o && n < 20) begin
            step(1);
            n++;
        end
        chk("start_len", n, 4);
        chk("busy_run", bus.busy_o, 1);
        wait_fall(len);
        chk("frame1", bus.frame_cnt_o, 1);
        chk("err1", bus.err_o, 0);

        // Commit in IDLE, last write concurrent with commit.
        step(2);
        write(10'h000, 8'hA5);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = 10'h3FF;
        bus.wr_data_i = 8'h5A;
        bus.commit_i  = 1'b1;
        step(1);
        bus.wr_en_i   = 1'b0;
        bus.commit_i  = 1'b0;
        chk("pend_ready", bus.wr_ready_o, 0);
        chk("ack_e0", bus.commit_ack_o, 0);
        step(1);
        chk("swap_ready", bus.wr_ready_o, 1);
        chk("ack_e1", bus.commit_ack_o, 0);
        step(1);
        chk("ack_e2", bus.commit_ack_o, 1);
        step(1);
        chk("ack_e3", bus.commit_ack_o, 0);
        sb.push_back('{10'h000, 8'hA5});
        sb.push_back('{10'h3FF, 8'h5A});
        wait_rise();
        wait_fall(len);
        chk("frame2", bus.frame_cnt_o, 2);
        sb_check();

        // Commit during RUN, plus a second commit while pending.
        step(2);
        write(10'h010, 8'h33);
        sb.push_back('{10'h000, 8'hA5});
        sb.push_back('{10'h3FF, 8'h5A});
        wait_rise();
        step(50);
        ack0 = ack_cnt;
        commit();
        chk("run_ready", bus.wr_ready_o, 0);
        write(10'h010, 8'h77);
        commit();
        step(5);
        chk("no_ack_run", ack_cnt, ack0);
        wait_fall(len);
        chk("frame3", bus.frame_cnt_o, 3);
        sb_check();
        step(3);
        chk("one_ack", ack_cnt, ack0 + 1);
        chk("ready_after", bus.wr_ready_o, 1);
        sb.push_back('{10'h010, 8'h33});
        wait_rise();
        wait_fall(len);
        chk("frame4", bus.frame_cnt_o, 4);
        chk("still_one_ack", ack_cnt, ack0 + 1);
        sb_check();

        // Stalled driver: watchdog fires, no count, no swap.
        stall = 1'b1;
        wait_rise();
        wait_fall(len);
        chk("timeout_len", len, 4100);
        chk("err_set", bus.err_o, 1);
        chk("frame_hold", bus.frame_cnt_o, 4);
        stall = 1'b0;

        // Disable mid-RUN: refresh completes, no further starts.
        sb.push_back('{10'h010, 8'h33});
        wait_rise();
        step(100);
        bus.enable_i = 1'b0;
        wait_fall(len);
        chk("frame5", bus.frame_cnt_o, 5);
        chk("err_sticky", bus.err_o, 1);
        sb_check();
        st0 = start_cnt;
        step(6000);
        chk("no_start", start_cnt, st0);

        // Async reset in the middle of a refresh with a commit pending.
        bus.enable_i = 1'b1;
        wait_rise();
        step(200);
        commit();
        chk("pre_rst_ready", bus.wr_ready_o, 0);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mr_start", bus.drv_start_o, 0);
        chk("mr_busy", bus.busy_o, 0);
        chk("mr_err", bus.err_o, 0);
        chk("mr_frame", bus.frame_cnt_o, 0);
        chk("mr_ack", bus.commit_ack_o, 0);
        chk("mr_ready", bus.wr_ready_o, 1);
        chk("mr_data", bus.drv_data_o, 0);
        drv_abort = 1'b1;
        step(3);
        rstn = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
